// File: rtl/aes_key_pkg.sv
// aes_key_pkg: key-length encodings, round counts and reader state type shared by the round-key reader.
package aes_key_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_RSV = 2'b11
    } key_len_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EXP,
        ST_FETCH,
        ST_CAPTURE,
        ST_PRESENT
    } state_e;

    // The reserved encoding falls back to AES-128.
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        return key_len == KL_192 ? NR_192 : key_len == KL_256 ? NR_256 : NR_128;
    endfunction
endpackage

// File: rtl/aes_rk_fetch.sv
// aes_rk_fetch: issues four consecutive word reads and assembles the returned words MSB-first into one round key.
module aes_rk_fetch #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                clr,
    input  logic [ADDR_W-1:0]   base,
    input  logic [WORD_W-1:0]   word_data,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   addr,
    output logic [4*WORD_W-1:0] key,
    output logic                full,
    output logic                last_rd,
    output logic                cap,
    output logic                busy
);
    // Phases 1..4 issue reads; phases 2..5 take the word read one cycle earlier.
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] base_q;

    assign busy    = cnt != 3'd0;
    assign cap     = cnt == 3'd5;
    assign last_rd = cnt == 3'd4;
    assign rd_en   = busy && !cap;
    assign addr    = rd_en ? base_q + ADDR_W'(cnt - 3'd1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 3'd0;
            base_q <= '0;
            key    <= '0;
            full   <= 1'b0;
        end else begin
            if (go) begin
                cnt    <= 3'd1;
                base_q <= base;
                full   <= 1'b0;
            end else if (busy) begin
                cnt  <= cap ? 3'd0 : cnt + 3'd1;
                full <= cap;
            end else if (clr) begin
                full <= 1'b0;
            end
            if (cnt >= 3'd2) key <= {key[3*WORD_W-1:0], word_data};
        end
    end
endmodule

// File: rtl/aes_round_key_reader.sv
// aes_round_key_reader: reads expanded-key words back four at a time and presents round keys over valid/next.
// Define AES_RK_PREFETCH_EN to fetch the following key into a second buffer while the current one is presented.
module aes_round_key_reader
    import aes_key_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic                Decrypt,
    input  logic [1:0]          KeyLen,
    input  logic                Expand_Done,
    output logic                Word_Rd_En,
    output logic [ADDR_W-1:0]   Word_Addr,
    input  logic [WORD_W-1:0]   Word_Data,
    output logic [4*WORD_W-1:0] RoundKey,
    output logic                RoundKey_Valid,
    input  logic                Next,
    output logic [3:0]          Round_Num,
    output logic                Last,
    output logic                Busy,
    output logic                Done
);
    state_e            state;
    logic              dec;
    logic              done_q;
    logic              valid;
    logic              hs;
    logic              adv;
    logic              start_ok;
    logic              exp_go;
    logic [3:0]        nr;
    logic [3:0]        r;
    logic [3:0]        rn;
    logic              act_last_rd;
    logic              act_cap;
    logic              oth_full;
    logic [ADDR_W-1:0] base_cur;
    logic [ADDR_W-1:0] base_nxt;

    assign valid    = state == ST_PRESENT;
    assign Last     = valid && (dec ? r == 4'd0 : r == nr);
    assign hs       = valid && Next;
    assign adv      = hs && !Last;
    assign start_ok = state == ST_IDLE && Start;
    assign exp_go   = state == ST_WAIT_EXP && Expand_Done;
    assign rn       = dec ? r - 4'd1 : r + 4'd1;
    assign base_cur = ADDR_W'({r, 2'b00});
    assign base_nxt = ADDR_W'({rn, 2'b00});

    assign RoundKey_Valid = valid;
    assign Round_Num      = r;
    assign Busy           = state != ST_IDLE;
    assign Done           = done_q;

`ifdef AES_RK_PREFETCH_EN
    // Two buffers used ping-pong: sel names the one being presented.
    logic                sel;
    logic                pf_go;
    logic [1:0]          go;
    logic [1:0]          clr;
    logic [1:0]          rd;
    logic [1:0]          full;
    logic [1:0]          lrd;
    logic [1:0]          cp;
    logic [1:0]          bsy;
    logic [ADDR_W-1:0]   addr [2];
    logic [4*WORD_W-1:0] key  [2];

    assign pf_go = valid && !Last && !bsy[~sel] && !full[~sel];

    for (genvar i = 0; i < 2; i++) begin : g_fetch
        localparam logic id = (i == 1);
        assign go[i]  = (exp_go && !id) || (pf_go && sel != id);
        assign clr[i] = start_ok || (adv && sel == id);
        aes_rk_fetch #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_fetch (
            .clk(Clk), .rst(Rst), .go(go[i]), .clr(clr[i]),
            .base(exp_go ? base_cur : base_nxt), .word_data(Word_Data),
            .rd_en(rd[i]), .addr(addr[i]), .key(key[i]), .full(full[i]),
            .last_rd(lrd[i]), .cap(cp[i]), .busy(bsy[i])
        );
    end

    assign Word_Rd_En  = |rd;
    assign Word_Addr   = addr[0] | addr[1];
    assign RoundKey    = key[sel];
    assign act_last_rd = lrd[sel];
    assign act_cap     = cp[sel];
    assign oth_full    = full[~sel];

    always_ff @(posedge Clk) begin
        if (Rst || start_ok) sel <= 1'b0;
        else if (adv) sel <= ~sel;
    end
`else
    logic f_full;
    logic f_busy;
    logic unused_ok;

    aes_rk_fetch #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_fetch (
        .clk(Clk), .rst(Rst), .go(exp_go || adv), .clr(1'b0),
        .base(exp_go ? base_cur : base_nxt), .word_data(Word_Data),
        .rd_en(Word_Rd_En), .addr(Word_Addr), .key(RoundKey), .full(f_full),
        .last_rd(act_last_rd), .cap(act_cap), .busy(f_busy)
    );

    assign oth_full  = 1'b0;
    assign unused_ok = f_full ^ f_busy;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= ST_IDLE;
            dec    <= 1'b0;
            nr     <= 4'd0;
            r      <= 4'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= hs && Last;
            case (state)
                ST_IDLE: if (start_ok) begin
                    state <= ST_WAIT_EXP;
                    dec   <= Decrypt;
                    nr    <= nr_of(KeyLen);
                    r     <= Decrypt ? nr_of(KeyLen) : 4'd0;
                end
                ST_WAIT_EXP: if (Expand_Done) state <= ST_FETCH;
                // A prefetch already in its capture phase completes straight into PRESENT.
                ST_FETCH:   state <= act_cap ? ST_PRESENT : act_last_rd ? ST_CAPTURE : ST_FETCH;
                ST_CAPTURE: state <= ST_PRESENT;
                ST_PRESENT: if (hs) begin
                    state <= Last ? ST_IDLE : oth_full ? ST_PRESENT : ST_FETCH;
                    if (!Last) r <= rn;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_key_reader.sv
// tb_aes_round_key_reader: randomized scoreboard bench; expected keys come from a word-memory model and the round order rules.
module tb_aes_round_key_reader;
    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic         Decrypt;
    logic [1:0]   KeyLen;
    logic         Expand_Done;
    logic         Word_Rd_En;
    logic [5:0]   Word_Addr;
    logic [31:0]  Word_Data = '0;
    logic [127:0] RoundKey;
    logic         RoundKey_Valid;
    logic         Next;
    logic [3:0]   Round_Num;
    logic         Last;
    logic         Busy;
    logic         Done;

    typedef struct {
        logic [127:0] key;
        int           rnd;
        bit           last;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] mem [64];
    int n_cmp, n_err, mode, cyc, fetch_start, dones, hs_cnt, vcnt, bubbles;
    int d0, h0, exp_hs;
    bit in_seq, rd_prev, valid_prev;

    aes_round_key_reader dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Decrypt(Decrypt), .KeyLen(KeyLen),
        .Expand_Done(Expand_Done), .Word_Rd_En(Word_Rd_En), .Word_Addr(Word_Addr),
        .Word_Data(Word_Data), .RoundKey(RoundKey), .RoundKey_Valid(RoundKey_Valid),
        .Next(Next), .Round_Num(Round_Num), .Last(Last), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (Word_Rd_En) Word_Data <= mem[Word_Addr];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int nr_m(input int kl);
        return kl == 1 ? 12 : kl == 2 ? 14 : 10;
    endfunction

    function automatic logic [127:0] exp_key(input int r);
        return {mem[4*r], mem[4*r+1], mem[4*r+2], mem[4*r+3]};
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic kick(input bit dec, input int kl, input bit ed);
        int nr = nr_m(kl);
        exp_hs  = nr + 1;
        d0      = dones;
        h0      = hs_cnt;
        bubbles = 0;
        for (int i = 0; i <= nr; i++) q.push_back('{exp_key(dec ? nr - i : i), dec ? nr - i : i, i == nr});
        tick;
        Expand_Done = ed;
        Decrypt     = dec;
        KeyLen      = 2'(kl);
        Start       = 1'b1;
        tick;
        Start = 1'b0;
    endtask

    task automatic finish_seq;
        int n = 0;
        while (dones == d0 && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        repeat (3) @(negedge Clk);
        chk("done_pulses", dones - d0, 1);
        chk("handshakes", hs_cnt - h0, exp_hs);
        chk("queue_drained", q.size(), 0);
`ifdef AES_RK_PREFETCH_EN
        if (mode == 3) chk("zero_bubble", bubbles, 0);
`endif
    endtask

    task automatic wait_valid;
        int n = 0;
        while (!RoundKey_Valid && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("valid_seen", RoundKey_Valid, 1);
    endtask

    initial begin
        Next = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            case (mode)
                0:       Next = 1'b1;
                1:       Next = 1'($urandom_range(0, 1));
                2:       Next = 1'b0;
                default: Next = vcnt >= 6;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and tracks pulses and gaps.
    always @(negedge Clk) begin
        cyc++;
        if (Done) dones++;
        if (Word_Rd_En && !rd_prev) fetch_start = cyc;
`ifndef AES_RK_PREFETCH_EN
        if (RoundKey_Valid && !valid_prev) chk("fetch_to_valid", cyc - fetch_start, 5);
`endif
        if (!RoundKey_Valid) chk("last_without_valid", Last, 0);
        if (RoundKey_Valid && Next) begin
            hs_cnt++;
            vcnt = 0;
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_key: got round %0d expected none", Round_Num);
            end else begin
                e = q.pop_front();
                chk("round_key", RoundKey, e.key);
                chk("round_num", Round_Num, e.rnd);
                chk("last_flag", Last, e.last);
            end
        end else if (RoundKey_Valid) vcnt++;
        else vcnt = 0;
        if (Done) in_seq = 0;
        else if (RoundKey_Valid) in_seq = 1;
        else if (in_seq && mode == 3) bubbles++;
        rd_prev    = Word_Rd_En;
        valid_prev = RoundKey_Valid;
    end

    initial begin
        int n;
        Rst = 1'b1; Start = 1'b0; Decrypt = 1'b0; KeyLen = 2'b00; Expand_Done = 1'b0; mode = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        repeat (3) tick;
        @(negedge Clk);
        chk("reset_key", RoundKey, 0);
        chk("reset_ctrl", {Word_Rd_En, Word_Addr, RoundKey_Valid, Round_Num, Last, Busy, Done}, 0);
        Rst = 1'b0;

        mode = 0;
        kick(0, 0, 1);
        finish_seq;
        mode = 1;
        kick(1, 2, 1);
        finish_seq;

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mode = 2;
        kick(0, 1, 1);
        wait_valid;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            chk("bp_valid", RoundKey_Valid, 1);
            chk("bp_key", RoundKey, exp_key(0));
            chk("bp_round", Round_Num, 0);
`ifndef AES_RK_PREFETCH_EN
            chk("bp_no_read", Word_Rd_En, 0);
`endif
        end
        mode = 0;
        finish_seq;

        kick(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            chk("wait_busy", Busy, 1);
            chk("wait_no_read", Word_Rd_En, 0);
        end
        tick;
        Expand_Done = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("exp_first_read", Word_Rd_En, 1);
        chk("exp_first_addr", Word_Addr, 0);
        n = 0;
        while (!RoundKey_Valid && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("exp_latency", n, 5);
        finish_seq;

        q.delete();
        tick;
        Decrypt = 1'b0; KeyLen = 2'b00; Expand_Done = 1'b1; Start = 1'b1;
        tick;
        Start = 1'b0;
        n = 0;
        while (!(Word_Rd_En && Word_Addr == 6'd2) && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("third_fetch_seen", Word_Rd_En && Word_Addr == 6'd2, 1);
        Rst = 1'b1;
        @(negedge Clk);
        chk("abort_key", RoundKey, 0);
        chk("abort_ctrl", {Word_Rd_En, Word_Addr, RoundKey_Valid, Round_Num, Last, Busy, Done}, 0);
        Rst = 1'b0;
        kick(0, 0, 1);
        finish_seq;

        mode = 1;
        kick(0, 3, 1);
        finish_seq;
        mode = 3;
        kick(0, 0, 1);
        finish_seq;

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            mode = 1;
            kick(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1);
            finish_seq;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
